// File: rtl/sdp_bram_clr_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sdp_bram_clr_if : port bundle for the clearable simple-dual-port RAM     |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
interface sdp_bram_clr_if #(
    parameter int DATA_W = 75,
    parameter int ADDR_W = 10
);
    logic              clr;
    logic              busy;
    logic              wea;
    logic [ADDR_W-1:0] addra;
    logic [DATA_W-1:0] dina;
    logic              reb;
    logic [ADDR_W-1:0] addrb;
    logic [DATA_W-1:0] doutb;
    logic              doutb_vld;

    modport master (
        output clr, wea, addra, dina, reb, addrb,
        input  busy, doutb, doutb_vld
    );

    modport slave (
        input  clr, wea, addra, dina, reb, addrb,
        output busy, doutb, doutb_vld
    );
endinterface
`default_nettype wire

// File: rtl/sdp_bram_clr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sdp_bram_clr : single-clock SDP RAM, write-first forwarding, HW clear    |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module sdp_bram_clr #(
    parameter int DATA_W     = 75,
    parameter int ADDR_W     = 10,
    parameter int RD_LAT     = 1,
    parameter int CLR_ON_RST = 1
) (
    input  logic         clk,
    input  logic         rst,
    sdp_bram_clr_if.slave bram
);
    localparam int c_DEPTH = 1 << ADDR_W;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    localparam state_t c_RST_STATE = (CLR_ON_RST != 0) ? S_CLEAR : S_IDLE;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic [ADDR_W-1:0] w_clr_cnt_nxt;
    logic              w_busy;
    logic              w_rd_acc;
    logic              w_fwd;
    logic [DATA_W-1:0] r_mem [c_DEPTH];
    logic [DATA_W-1:0] r_s1_data;
    logic              r_s1_vld;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_RST_STATE;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        case (r_state)
            S_IDLE: begin
                if (bram.clr) begin
                    w_state_nxt   = S_CLEAR;
                    w_clr_cnt_nxt = '0;
                end
            end
            S_CLEAR: begin
                // counter wraps to zero on the last word, ready for the next clear
                w_clr_cnt_nxt = r_clr_cnt + 1'b1;
                if (r_clr_cnt == '1) begin
                    w_state_nxt = S_IDLE;
                end
            end
        endcase
    end

    assign w_busy    = (r_state == S_CLEAR);
    assign bram.busy = w_busy;

    // Single write port: the clear engine owns it while busy
    always_ff @(posedge clk) begin
        if (w_busy) begin
            r_mem[r_clr_cnt] <= '0;
        end else if (bram.wea) begin
            r_mem[bram.addra] <= bram.dina;
        end
    end

    assign w_rd_acc = bram.reb & ~w_busy;
    assign w_fwd    = bram.wea && (bram.addra == bram.addrb);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_vld  <= 1'b0;
            r_s1_data <= '0;
        end else begin
            r_s1_vld <= w_rd_acc;
            if (w_rd_acc) begin
                r_s1_data <= w_fwd ? bram.dina : r_mem[bram.addrb];
            end
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic [DATA_W-1:0] r_s2_data;
            logic              r_s2_vld;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_s2_vld  <= 1'b0;
                    r_s2_data <= '0;
                end else begin
                    r_s2_vld <= r_s1_vld;
                    if (r_s1_vld) begin
                        r_s2_data <= r_s1_data;
                    end
                end
            end

            assign bram.doutb     = r_s2_data;
            assign bram.doutb_vld = r_s2_vld;
        end else begin : g_lat1
            assign bram.doutb     = r_s1_data;
            assign bram.doutb_vld = r_s1_vld;
        end
    endgenerate
endmodule
`default_nettype wire

// File: tb/tb_sdp_bram_clr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sdp_bram_clr : bench for sdp_bram_clr, RD_LAT=1 and RD_LAT=2 in step  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_sdp_bram_clr;
    logic clk;
    logic rst;

    sdp_bram_clr_if #(.DATA_W(8), .ADDR_W(4)) if1 ();
    sdp_bram_clr_if #(.DATA_W(8), .ADDR_W(4)) if2 ();

    sdp_bram_clr #(.DATA_W(8), .ADDR_W(4), .RD_LAT(1), .CLR_ON_RST(1)) u_dut1 (
        .clk  (clk),
        .rst  (rst),
        .bram (if1)
    );

    sdp_bram_clr #(.DATA_W(8), .ADDR_W(4), .RD_LAT(2), .CLR_ON_RST(1)) u_dut2 (
        .clk  (clk),
        .rst  (rst),
        .bram (if2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       wea;
        logic [3:0] addra;
        logic [7:0] dina;
        logic       reb;
        logic [3:0] addrb;
        logic       v1;
        logic [7:0] d1;
        logic       v2;
        logic [7:0] d2;
    } vec_t;

    vec_t       vecs [15];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] last1  = 8'h00;
    logic [7:0] last2  = 8'h00;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_o1(input string nm, input logic ev, input logic [7:0] ed);
        chk({nm, "_vld1"}, {31'd0, if1.doutb_vld}, {31'd0, ev});
        if (ev) last1 = ed;
        chk({nm, "_dout1"}, {24'd0, if1.doutb}, {24'd0, last1});
    endtask

    task automatic chk_o2(input string nm, input logic ev, input logic [7:0] ed);
        chk({nm, "_vld2"}, {31'd0, if2.doutb_vld}, {31'd0, ev});
        if (ev) last2 = ed;
        chk({nm, "_dout2"}, {24'd0, if2.doutb}, {24'd0, last2});
    endtask

    task automatic set_in(input logic c, input logic we, input logic [3:0] aa,
                          input logic [7:0] da, input logic re, input logic [3:0] ab);
        if1.clr = c;  if1.wea = we; if1.addra = aa; if1.dina = da; if1.reb = re; if1.addrb = ab;
        if2.clr = c;  if2.wea = we; if2.addra = aa; if2.dina = da; if2.reb = re; if2.addrb = ab;
    endtask

    task automatic drive(input logic c, input logic we, input logic [3:0] aa,
                         input logic [7:0] da, input logic re, input logic [3:0] ab);
        @(negedge clk);
        set_in(c, we, aa, da, re, ab);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts consecutive busy-high samples starting now; no read may complete meanwhile
    task automatic count_busy(input string nm, input int exp_n);
        int n1 = 0;
        int n2 = 0;
        int nv = 0;
        for (int k = 0; k < 40; k++) begin
            if (if1.busy) n1++;
            if (if2.busy) n2++;
            if (if1.doutb_vld) nv++;
            if (if2.doutb_vld) nv++;
            if (!if1.busy && !if2.busy) break;
            tick();
        end
        chk({nm, "_cnt1"}, n1, exp_n);
        chk({nm, "_cnt2"}, n2, exp_n);
        chk({nm, "_vld"}, nv, 0);
    endtask

    task automatic stream(input string nm, input bit pat);
        for (int i = 0; i < 18; i++) begin
            drive(1'b0, 1'b0, 4'd0, 8'h00, (i < 16), i[3:0]);
            tick();
            chk_o1($sformatf("%s_%0d", nm, i), (i < 16), pat ? 8'(8'h80 + i) : 8'h00);
            chk_o2($sformatf("%s_%0d", nm, i), (i >= 1 && i < 17), pat ? 8'(8'h80 + i - 1) : 8'h00);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //              wea addra dina   reb addrb  v1  d1     v2  d2
        vecs[0]  = '{1'b0, 4'd0,  8'h00, 1'b1, 4'd0,  1'b1, 8'h00, 1'b0, 8'h00};
        vecs[1]  = '{1'b0, 4'd0,  8'h00, 1'b1, 4'd5,  1'b1, 8'h00, 1'b1, 8'h00};
        vecs[2]  = '{1'b0, 4'd0,  8'h00, 1'b1, 4'd15, 1'b1, 8'h00, 1'b1, 8'h00};
        vecs[3]  = '{1'b1, 4'd3,  8'hA5, 1'b0, 4'd0,  1'b0, 8'h00, 1'b1, 8'h00};
        vecs[4]  = '{1'b1, 4'd15, 8'h5A, 1'b0, 4'd0,  1'b0, 8'h00, 1'b0, 8'h00};
        vecs[5]  = '{1'b0, 4'd0,  8'h00, 1'b1, 4'd3,  1'b1, 8'hA5, 1'b0, 8'h00};
        vecs[6]  = '{1'b0, 4'd0,  8'h00, 1'b1, 4'd15, 1'b1, 8'h5A, 1'b1, 8'hA5};
        vecs[7]  = '{1'b1, 4'd7,  8'h11, 1'b0, 4'd0,  1'b0, 8'h00, 1'b1, 8'h5A};
        vecs[8]  = '{1'b0, 4'd0,  8'h00, 1'b1, 4'd7,  1'b1, 8'h11, 1'b0, 8'h00};
        vecs[9]  = '{1'b1, 4'd7,  8'h3C, 1'b1, 4'd7,  1'b1, 8'h3C, 1'b1, 8'h11};
        vecs[10] = '{1'b0, 4'd0,  8'h00, 1'b1, 4'd7,  1'b1, 8'h3C, 1'b1, 8'h3C};
        vecs[11] = '{1'b1, 4'd2,  8'h77, 1'b1, 4'd3,  1'b1, 8'hA5, 1'b1, 8'h3C};
        vecs[12] = '{1'b0, 4'd0,  8'h00, 1'b1, 4'd2,  1'b1, 8'h77, 1'b1, 8'hA5};
        vecs[13] = '{1'b0, 4'd0,  8'h00, 1'b0, 4'd0,  1'b0, 8'h00, 1'b1, 8'h77};
        vecs[14] = '{1'b0, 4'd0,  8'h00, 1'b0, 4'd0,  1'b0, 8'h00, 1'b0, 8'h00};

        rst = 1'b1;
        set_in(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
        #2;
        chk("rst_busy1", {31'd0, if1.busy}, 32'd1);
        chk("rst_busy2", {31'd0, if2.busy}, 32'd1);
        chk_o1("rst", 1'b0, 8'h00);
        chk_o2("rst", 1'b0, 8'h00);
        tick();
        tick();
        @(negedge clk);
        rst = 1'b0;
        #1;
        count_busy("busy_rst", 16);

        stream("rd_zero", 1'b0);

        for (int i = 0; i < 15; i++) begin
            drive(1'b0, vecs[i].wea, vecs[i].addra, vecs[i].dina, vecs[i].reb, vecs[i].addrb);
            tick();
            chk($sformatf("vec%0d_busy", i), {31'd0, if1.busy | if2.busy}, 32'd0);
            chk_o1($sformatf("vec%0d", i), vecs[i].v1, vecs[i].d1);
            chk_o2($sformatf("vec%0d", i), vecs[i].v2, vecs[i].d2);
        end

        for (int a = 0; a < 16; a++) begin
            drive(1'b0, 1'b1, a[3:0], 8'(8'h80 + a), 1'b0, 4'd0);
            tick();
        end
        stream("rd_pat", 1'b1);

        // clr together with a read of 4: that read returns its pre-clear word
        drive(1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 4'd4);
        tick();
        chk("clr_busy_start", {31'd0, if1.busy & if2.busy}, 32'd1);
        chk_o1("clr_inflight", 1'b1, 8'h84);
        chk_o2("clr_inflight", 1'b0, 8'h00);
        drive(1'b1, 1'b1, 4'd2, 8'hFF, 1'b1, 4'd2);
        begin
            int n = 1;
            for (int k = 0; k < 40; k++) begin
                tick();
                chk_o1($sformatf("clr_busy_%0d", k), 1'b0, 8'h00);
                chk_o2($sformatf("clr_busy_%0d", k), (k == 0), 8'h84);
                if (if1.busy) n++;
                else break;
            end
            chk("clr_busy_cnt", n, 16);
        end
        drive(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
        tick();
        chk("clr_no_restart", {31'd0, if1.busy | if2.busy}, 32'd0);
        stream("rd_clr", 1'b0);

        // reset in the middle of a clear, with nonzero data on both outputs
        drive(1'b0, 1'b1, 4'd5, 8'h5A, 1'b0, 4'd0);
        tick();
        drive(1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 4'd5);
        tick();
        chk_o1("mclr_rd", 1'b1, 8'h5A);
        drive(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
        tick();
        chk_o2("mclr_rd", 1'b1, 8'h5A);
        for (int k = 0; k < 6; k++) tick();
        chk("mclr_busy_pre", {31'd0, if1.busy & if2.busy}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        last1 = 8'h00;
        last2 = 8'h00;
        chk_o1("mclr_rst", 1'b0, 8'h00);
        chk_o2("mclr_rst", 1'b0, 8'h00);
        tick();
        @(negedge clk);
        rst = 1'b0;
        #1;
        count_busy("busy_mclr", 16);

        // reset while the RD_LAT=2 pipeline still holds a read
        drive(1'b0, 1'b1, 4'd6, 8'h66, 1'b0, 4'd0);
        tick();
        drive(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'd6);
        tick();
        chk_o1("mrd_rd", 1'b1, 8'h66);
        chk_o2("mrd_rd", 1'b0, 8'h00);
        set_in(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
        rst = 1'b1;
        #1;
        last1 = 8'h00;
        last2 = 8'h00;
        chk_o1("mrd_rst", 1'b0, 8'h00);
        chk_o2("mrd_rst", 1'b0, 8'h00);
        chk("mrd_rst_busy", {31'd0, if1.busy & if2.busy}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        count_busy("busy_mrd", 16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
